mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
// Shares one single-port RAM between two bus masters using the core's native memory signalling (addr/rstrb/wdata/wmask).
// Typical hookup: m0 = RISC-V core load/store/fetch port, m1 = UART program loader or DMA.
// Fair two-way round-robin arbitration; busy/rvalid handshake back to each master.
// One transaction in flight at a time.
// PARAMETERS
// ADDR_W    32  byte-address width on all ports
// RAM_LAT   1   RAM read latency in cycles: ram_rdata valid RAM_LAT cycles after ram_rstrb; legal 1..4
// PRIO_RST  0   master index holding priority after reset
// PORTS
// CLK        in   1       system clock
// RESET      in   1       synchronous, active-high reset
// m0_addr    in   ADDR_W  master 0 byte address
// m0_rstrb   in   1       master 0 read request (level)
// m0_wdata   in   32      master 0 write data
// m0_wmask   in   4       master 0 byte write enables; nonzero = write request
// m0_rdata   out  32      read data; passthrough of ram_rdata, qualified by m0_rvalid
// m0_rvalid  out  1       one-cycle pulse: m0 read data valid
// m0_busy    out  1       1 = m0 request pending, not yet completed
// m1_*       -    -       identical set for master 1
// ram_addr   out  ADDR_W  RAM address
// ram_rstrb  out  1       RAM read strobe, one cycle per read
// ram_wdata  out  32      RAM write data
// ram_wmask  out  4       RAM byte write enables, one cycle per write
// ram_rdata  in   32      RAM read data
// BEHAVIOUR
// - reqN = mN_rstrb | (|mN_wmask). A master holds addr/wdata/wmask/rstrb stable while mN_busy=1.
// - mN_busy = reqN & !doneN (combinational). doneN = write-issue cycle or rvalid cycle for that master.
// - A request still asserted in the cycle after doneN is a new transaction.
// - States: IDLE, RD_WAIT. Registers: state, gnt (1b), prio (1b), cnt (2..3b), latched addr.
// - IDLE, no request: ram_rstrb=0, ram_wmask=0, ram_addr=last value.
// - IDLE, one request: grant that master.
// - IDLE, both request: grant prio.
// - Grant is combinational in the same cycle; the winner's addr/wdata/wmask/rstrb drive RAM that cycle (issue cycle).
// - Write issue: ram_wmask=winner wmask, done that cycle, stay IDLE, prio <= ~winner.
// - Read issue: ram_rstrb=1, latch gnt/addr, cnt <= RAM_LAT-1, go to RD_WAIT.
//   - If RAM_LAT=1, the data cycle is the next cycle.
// - RD_WAIT: ram_rstrb=0, ram_wmask=0, ram_addr=latched addr. All new requests stall (busy=1).
//   - cnt decrements each cycle.
//   - In the cycle cnt==0 (issue+RAM_LAT): m[gnt]_rvalid=1, state <= IDLE, prio <= ~gnt.
//   - No new issue in this same cycle; minimum read turnaround is RAM_LAT+1 cycles.
// - rstrb and wmask both set by one master: treated as a write; rstrb ignored. Simulation assertion flags it.
// - Loser of a simultaneous request waits, then wins the next arbitration, so no starvation. Max wait = one transaction.
// - mN_rdata = ram_rdata always; only mN_rvalid is qualified.
// - RESET, including mid-read: state=IDLE, prio=PRIO_RST, cnt=0, ram_addr=0, ram_rstrb=0, ram_wmask=0, rvalid=0, busy=0 while RESET high.
//   - A pending read is discarded; no rvalid is ever emitted for it.
// STRUCTURE
// - Shared include mem_bus_defs.vh: state encodings (ST_IDLE, ST_RD_WAIT), WMASK_W=4, DATA_W=32.
// - Sub-module rr_arb2: combinational 2-way round-robin pick. Inputs req[1:0], prio; output gnt.
// - FSM, counter, muxes and prio update live in mem_arbiter.
// TESTING
// 1. m0 write addr=0x10 wdata=0xDEADBEEF wmask=4'b1111, m1 idle -> ram_wmask=1111 and ram_addr=0x10 same cycle; m0_busy=0; prio=1 next cycle.
// 2. m1 read addr=0x20, RAM_LAT=1, RAM holds 0x12345678 -> ram_rstrb 1 cycle; next cycle m1_rvalid=1, m1_rdata=0x12345678; m0_rvalid=0.
// 3. Both read every cycle, prio=0 -> grants alternate m0,m1,m0,m1; each rvalid 2 cycles apart; neither busy >4 cycles.
// 4. m0 write during m1 RD_WAIT with RAM_LAT=3 -> m0_busy=1 and ram_wmask=0 for 3 cycles; write issues the cycle after m1_rvalid.
// 5. RESET pulsed one cycle after a read issue -> no rvalid follows; next cycle state=IDLE; a fresh request is served normally.
// 6. m0 rstrb=1 with wmask=0011 -> write of low halfword only; no ram_rstrb; no rvalid; assertion fires.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-master single-port RAM arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state encoding, bus widths, read-latency counter width, request helper.
package mem_arbiter_pkg;

  localparam int DATA_W  = 32;
  localparam int WMASK_W = 4;
  // Holds RAM_LAT-1 for RAM_LAT in 1..4.
  localparam int CNT_W   = 2;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RD_WAIT = 1'b1
  } state_t;

  // A master is requesting when it strobes a read or enables any write byte.
  function automatic logic is_req(input logic rstrb, input logic [WMASK_W-1:0] wmask);
    return rstrb | (|wmask);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Native memory bus of one master (addr/rstrb/wdata/wmask out, rdata/rvalid/busy back).
// Latency: n/a (signal bundle only).
// Backpressure: busy=1 means the master must hold its request signals stable.
// Modports: master = bus initiator side, slave = arbiter side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  import mem_arbiter_pkg::*;

  logic [ADDR_W-1:0]  addr;
  logic               rstrb;
  logic [DATA_W-1:0]  wdata;
  logic [WMASK_W-1:0] wmask;
  logic [DATA_W-1:0]  rdata;
  logic               rvalid;
  logic               busy;

  modport master (
    output addr, rstrb, wdata, wmask,
    input  rdata, rvalid, busy
  );

  modport slave (
    input  addr, rstrb, wdata, wmask,
    output rdata, rvalid, busy
  );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin pick, purely combinational.
// Latency: 0 cycles.
// Backpressure: none; caller decides when the pick is consumed.
// Ports: req[1:0] requests, prio = index favoured on a tie, gnt = winning index.
module mem_arbiter_rr_arb2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic       gnt
);

  always_comb begin
    gnt = req[1];
    if (&req) begin
      gnt = prio;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port RAM between two masters with fair round-robin, one transaction in flight.
// Latency: writes issue in the request cycle; reads return RAM_LAT cycles after issue.
// Backpressure: mN.busy stays high until the write issues or the read's rvalid cycle.
// Ports: clk, RESET (sync, active high); m0/m1 master buses; ram_* single-port RAM side.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int   ADDR_W   = 32,
  parameter int   RAM_LAT  = 1,     // legal 1..4
  parameter logic PRIO_RST = 1'b0
) (
  input  logic               clk,
  input  logic               RESET,
  mem_arbiter_if.slave       m0,
  mem_arbiter_if.slave       m1,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic               ram_rstrb,
  output logic [DATA_W-1:0]  ram_wdata,
  output logic [WMASK_W-1:0] ram_wmask,
  input  logic [DATA_W-1:0]  ram_rdata
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RAM_LAT - 1);

  state_t             state_q, state_d;
  logic               gnt_q, gnt_d;
  logic               prio_q, prio_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;

  logic               req0, req1, arb_gnt;
  logic [ADDR_W-1:0]  win_addr;
  logic [DATA_W-1:0]  win_wdata;
  logic [WMASK_W-1:0] win_wmask;
  logic               done0, done1, rvalid0, rvalid1;

  assign req0 = is_req(m0.rstrb, m0.wmask);
  assign req1 = is_req(m1.rstrb, m1.wmask);

  mem_arbiter_rr_arb2 u_rr_arb2 (
    .req  ({req1, req0}),
    .prio (prio_q),
    .gnt  (arb_gnt)
  );

  // Winner's bus, used only in the IDLE issue cycle.
  always_comb begin
    win_addr  = arb_gnt ? m1.addr  : m0.addr;
    win_wdata = arb_gnt ? m1.wdata : m0.wdata;
    win_wmask = arb_gnt ? m1.wmask : m0.wmask;
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    prio_d    = prio_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    ram_addr  = addr_q;
    ram_rstrb = 1'b0;
    ram_wmask = '0;
    ram_wdata = win_wdata;
    done0     = 1'b0;
    done1     = 1'b0;
    rvalid0   = 1'b0;
    rvalid1   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req0 | req1) begin
          ram_addr = win_addr;
          addr_d   = win_addr;
          gnt_d    = arb_gnt;
          // Any wmask bit makes it a write; a simultaneous rstrb is ignored.
          if (|win_wmask) begin
            ram_wmask = win_wmask;
            done0     = ~arb_gnt;
            done1     = arb_gnt;
            prio_d    = ~arb_gnt;
          end else begin
            ram_rstrb = 1'b1;
            cnt_d     = CNT_LOAD;
            state_d   = ST_RD_WAIT;
          end
        end
      end

      ST_RD_WAIT: begin
        // Data cycle: ram_rdata is valid now. No new issue until IDLE.
        if (cnt_q == '0) begin
          rvalid0 = ~gnt_q;
          rvalid1 = gnt_q;
          done0   = ~gnt_q;
          done1   = gnt_q;
          prio_d  = ~gnt_q;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Outputs are quiet while reset is held, even mid-read.
    if (RESET) begin
      ram_addr  = '0;
      ram_rstrb = 1'b0;
      ram_wmask = '0;
      done0     = 1'b0;
      done1     = 1'b0;
      rvalid0   = 1'b0;
      rvalid1   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      gnt_q   <= 1'b0;
      prio_q  <= PRIO_RST;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  assign m0.rdata  = ram_rdata;
  assign m1.rdata  = ram_rdata;
  assign m0.rvalid = rvalid0;
  assign m1.rvalid = rvalid1;
  assign m0.busy   = req0 & ~done0 & ~RESET;
  assign m1.busy   = req1 & ~done1 & ~RESET;

  // Read and write together from one master is a master bug; it is served as a write.
  always_ff @(posedge clk) begin
    if (!RESET) begin
      a_m0_rw_excl: assert (!(m0.rstrb && (|m0.wmask)))
        else $warning("m0 asserted rstrb with nonzero wmask; handled as write");
      a_m1_rw_excl: assert (!(m1.rstrb && (|m1.wmask)))
        else $warning("m1 asserted rstrb with nonzero wmask; handled as write");
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with RAM_LAT=1, one with RAM_LAT=3.
// Each has a behavioural byte-maskable RAM with the matching read latency.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic RESET;
  logic mem_init;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // ---------------- RAM_LAT = 1 instance ----------------
  mem_arbiter_if #(.ADDR_W(32)) u1_m0 ();
  mem_arbiter_if #(.ADDR_W(32)) u1_m1 ();
  logic [31:0] r1_addr;
  logic        r1_rstrb;
  logic [31:0] r1_wdata;
  logic [3:0]  r1_wmask;
  logic [31:0] r1_rdata;
  logic [31:0] mem1 [0:63];

  mem_arbiter #(.ADDR_W(32), .RAM_LAT(1), .PRIO_RST(1'b0)) u_dut1 (
    .clk       (clk),
    .RESET     (RESET),
    .m0        (u1_m0),
    .m1        (u1_m1),
    .ram_addr  (r1_addr),
    .ram_rstrb (r1_rstrb),
    .ram_wdata (r1_wdata),
    .ram_wmask (r1_wmask),
    .ram_rdata (r1_rdata)
  );

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem1[i] <= 32'hA000_0000 + i;
      mem1[8] <= 32'h1234_5678;
    end else begin
      for (int i = 0; i < 4; i++)
        if (r1_wmask[i]) mem1[r1_addr[7:2]][8*i +: 8] <= r1_wdata[8*i +: 8];
    end
    if (r1_rstrb) r1_rdata <= mem1[r1_addr[7:2]];
  end

  // ---------------- RAM_LAT = 3 instance ----------------
  mem_arbiter_if #(.ADDR_W(32)) u3_m0 ();
  mem_arbiter_if #(.ADDR_W(32)) u3_m1 ();
  logic [31:0] r3_addr;
  logic        r3_rstrb;
  logic [31:0] r3_wdata;
  logic [3:0]  r3_wmask;
  logic [31:0] r3_rdata;
  logic [31:0] r3_p1, r3_p2;
  logic [31:0] mem3 [0:63];

  mem_arbiter #(.ADDR_W(32), .RAM_LAT(3), .PRIO_RST(1'b0)) u_dut3 (
    .clk       (clk),
    .RESET     (RESET),
    .m0        (u3_m0),
    .m1        (u3_m1),
    .ram_addr  (r3_addr),
    .ram_rstrb (r3_rstrb),
    .ram_wdata (r3_wdata),
    .ram_wmask (r3_wmask),
    .ram_rdata (r3_rdata)
  );

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem3[i] <= 32'hB000_0000 + i;
      mem3[8] <= 32'hCAFE_F00D;
    end else begin
      for (int i = 0; i < 4; i++)
        if (r3_wmask[i]) mem3[r3_addr[7:2]][8*i +: 8] <= r3_wdata[8*i +: 8];
    end
    if (r3_rstrb) r3_p1 <= mem3[r3_addr[7:2]];
    r3_p2    <= r3_p1;
    r3_rdata <= r3_p2;
  end

  // ---------------- helpers ----------------
  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drv10(input logic [31:0] a, input logic r, input logic [31:0] d, input logic [3:0] m);
    u1_m0.addr = a; u1_m0.rstrb = r; u1_m0.wdata = d; u1_m0.wmask = m;
  endtask
  task automatic drv11(input logic [31:0] a, input logic r, input logic [31:0] d, input logic [3:0] m);
    u1_m1.addr = a; u1_m1.rstrb = r; u1_m1.wdata = d; u1_m1.wmask = m;
  endtask
  task automatic drv30(input logic [31:0] a, input logic r, input logic [31:0] d, input logic [3:0] m);
    u3_m0.addr = a; u3_m0.rstrb = r; u3_m0.wdata = d; u3_m0.wmask = m;
  endtask
  task automatic drv31(input logic [31:0] a, input logic r, input logic [31:0] d, input logic [3:0] m);
    u3_m1.addr = a; u3_m1.rstrb = r; u3_m1.wdata = d; u3_m1.wmask = m;
  endtask

  // ---------------- directed sequence ----------------
  int ph, w;
  int run0, run1, max0, max1;

  initial begin
    RESET    = 1'b1;
    mem_init = 1'b1;
    drv10(32'h40, 1'b1, 32'h0, 4'h0);   // request held during reset must not show busy
    drv11(32'h0, 1'b0, 32'h0, 4'h0);
    drv30(32'h0, 1'b0, 32'h0, 4'h0);
    drv31(32'h0, 1'b0, 32'h0, 4'h0);
    #2;
    chk32("rst_ram_addr", r1_addr, 32'h0);
    chk1 ("rst_ram_rstrb", r1_rstrb, 1'b0);
    chk32("rst_ram_wmask", {28'h0, r1_wmask}, 32'h0);
    chk1 ("rst_m0_busy", u1_m0.busy, 1'b0);
    chk1 ("rst_m0_rvalid", u1_m0.rvalid, 1'b0);

    tick;
    mem_init = 1'b0;
    drv10(32'h0, 1'b0, 32'h0, 4'h0);
    tick;
    RESET = 1'b0;
    #1;
    chk32("post_rst_addr", r1_addr, 32'h0);
    chk1 ("post_rst_rstrb", r1_rstrb, 1'b0);
    chk32("post_rst_addr3", r3_addr, 32'h0);

    // Test 1: lone write issues in the request cycle.
    tick;
    drv10(32'h10, 1'b0, 32'hDEAD_BEEF, 4'hF);
    #1;
    chk32("t1_wmask", {28'h0, r1_wmask}, 32'hF);
    chk32("t1_addr", r1_addr, 32'h10);
    chk32("t1_wdata", r1_wdata, 32'hDEAD_BEEF);
    chk1 ("t1_m0_busy", u1_m0.busy, 1'b0);
    chk1 ("t1_rstrb", r1_rstrb, 1'b0);
    // prio is now 1: a tie goes to m1.
    tick;
    drv10(32'h14, 1'b0, 32'h1111_1111, 4'hF);
    drv11(32'h18, 1'b0, 32'h2222_2222, 4'hF);
    #1;
    chk32("t1_tie_addr", r1_addr, 32'h18);
    chk32("t1_tie_wdata", r1_wdata, 32'h2222_2222);
    chk1 ("t1_tie_m1_busy", u1_m1.busy, 1'b0);
    chk1 ("t1_tie_m0_busy", u1_m0.busy, 1'b1);
    tick;
    drv11(32'h0, 1'b0, 32'h0, 4'h0);
    #1;
    chk32("t1_loser_addr", r1_addr, 32'h14);
    chk1 ("t1_loser_busy", u1_m0.busy, 1'b0);
    tick;
    drv10(32'h0, 1'b0, 32'h0, 4'h0);
    #1;
    chk32("idle_addr_hold", r1_addr, 32'h14);
    chk32("idle_wmask", {28'h0, r1_wmask}, 32'h0);

    // Test 2: m1 read with RAM_LAT=1.
    tick;
    drv11(32'h20, 1'b1, 32'h0, 4'h0);
    #1;
    chk1 ("t2_rstrb", r1_rstrb, 1'b1);
    chk32("t2_addr", r1_addr, 32'h20);
    chk1 ("t2_m1_busy", u1_m1.busy, 1'b1);
    chk1 ("t2_m1_rvalid_early", u1_m1.rvalid, 1'b0);
    tick;
    #1;
    chk1 ("t2_rstrb_wait", r1_rstrb, 1'b0);
    chk1 ("t2_m1_rvalid", u1_m1.rvalid, 1'b1);
    chk32("t2_m1_rdata", u1_m1.rdata, 32'h1234_5678);
    chk1 ("t2_m0_rvalid", u1_m0.rvalid, 1'b0);
    chk1 ("t2_m1_busy_done", u1_m1.busy, 1'b0);
    tick;

    // Test 3: both masters read continuously; prio starts at 0.
    drv10(32'h10, 1'b1, 32'h0, 4'h0);
    drv11(32'h20, 1'b1, 32'h0, 4'h0);
    run0 = 0; run1 = 0; max0 = 0; max1 = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      ph = k % 2;
      w  = (k / 2) % 2;
      chk1 ("t3_rstrb", r1_rstrb, ph == 0);
      chk1 ("t3_m0_rvalid", u1_m0.rvalid, (ph == 1) && (w == 0));
      chk1 ("t3_m1_rvalid", u1_m1.rvalid, (ph == 1) && (w == 1));
      if (ph == 0) chk32("t3_addr", r1_addr, (w == 1) ? 32'h20 : 32'h10);
      else         chk32("t3_rdata", r1_rdata, (w == 1) ? 32'h1234_5678 : 32'hDEAD_BEEF);
      run0 = u1_m0.busy ? run0 + 1 : 0;
      run1 = u1_m1.busy ? run1 + 1 : 0;
      if (run0 > max0) max0 = run0;
      if (run1 > max1) max1 = run1;
      tick;
    end
    chk1("t3_m0_busy_max", max0 <= 4, 1'b1);
    chk1("t3_m1_busy_max", max1 <= 4, 1'b1);
    drv10(32'h0, 1'b0, 32'h0, 4'h0);
    drv11(32'h0, 1'b0, 32'h0, 4'h0);

    // Test 6: rstrb with partial wmask is a halfword write.
    drv10(32'h30, 1'b1, 32'hAAAA_5555, 4'b0011);
    #1;
    chk32("t6_wmask", {28'h0, r1_wmask}, 32'h3);
    chk1 ("t6_rstrb", r1_rstrb, 1'b0);
    chk1 ("t6_m0_busy", u1_m0.busy, 1'b0);
    tick;
    drv10(32'h0, 1'b0, 32'h0, 4'h0);
    #1;
    chk1 ("t6_no_rvalid", u1_m0.rvalid, 1'b0);
    chk1 ("t6_no_rstrb", r1_rstrb, 1'b0);
    tick;
    drv10(32'h30, 1'b1, 32'h0, 4'h0);
    #1;
    chk1 ("t6_rb_rstrb", r1_rstrb, 1'b1);
    tick;
    #1;
    chk1 ("t6_rb_rvalid", u1_m0.rvalid, 1'b1);
    chk32("t6_rb_rdata", u1_m0.rdata, 32'hA000_5555);
    tick;

    // Test 5: reset during the read's data cycle discards it.
    drv10(32'h10, 1'b1, 32'h0, 4'h0);
    #1;
    chk1 ("t5_issue", r1_rstrb, 1'b1);
    tick;
    RESET = 1'b1;
    #1;
    chk1 ("t5_rst_rvalid", u1_m0.rvalid, 1'b0);
    chk1 ("t5_rst_busy", u1_m0.busy, 1'b0);
    chk32("t5_rst_addr", r1_addr, 32'h0);
    tick;
    RESET = 1'b0;
    drv10(32'h0, 1'b0, 32'h0, 4'h0);
    #1;
    chk1 ("t5_post_m0_rvalid", u1_m0.rvalid, 1'b0);
    chk1 ("t5_post_m1_rvalid", u1_m1.rvalid, 1'b0);
    tick;
    drv10(32'h10, 1'b1, 32'h0, 4'h0);
    drv11(32'h20, 1'b1, 32'h0, 4'h0);
    #1;
    chk1 ("t5_fresh_rstrb", r1_rstrb, 1'b1);
    chk32("t5_fresh_addr", r1_addr, 32'h10);
    chk1 ("t5_fresh_m1_busy", u1_m1.busy, 1'b1);
    tick;
    drv11(32'h0, 1'b0, 32'h0, 4'h0);
    #1;
    chk1 ("t5_fresh_rvalid", u1_m0.rvalid, 1'b1);
    chk32("t5_fresh_rdata", u1_m0.rdata, 32'hDEAD_BEEF);
    tick;
    drv10(32'h0, 1'b0, 32'h0, 4'h0);

    // Test 4: RAM_LAT=3, m0 write stalls behind m1 read.
    drv31(32'h20, 1'b1, 32'h0, 4'h0);
    #1;
    chk1 ("t4_rstrb", r3_rstrb, 1'b1);
    tick;
    drv30(32'h40, 1'b0, 32'h55AA_55AA, 4'hF);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk1 ("t4_m0_busy", u3_m0.busy, 1'b1);
      chk32("t4_wmask", {28'h0, r3_wmask}, 32'h0);
      chk32("t4_addr", r3_addr, 32'h20);
      chk1 ("t4_m1_rvalid", u3_m1.rvalid, k == 2);
      if (k == 2) chk32("t4_m1_rdata", u3_m1.rdata, 32'hCAFE_F00D);
      tick;
    end
    drv31(32'h0, 1'b0, 32'h0, 4'h0);
    #1;
    chk32("t4_wr_wmask", {28'h0, r3_wmask}, 32'hF);
    chk32("t4_wr_addr", r3_addr, 32'h40);
    chk32("t4_wr_wdata", r3_wdata, 32'h55AA_55AA);
    chk1 ("t4_wr_busy", u3_m0.busy, 1'b0);
    tick;
    drv30(32'h0, 1'b0, 32'h0, 4'h0);
    #1;
    chk32("t4_after_wmask", {28'h0, r3_wmask}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
